acc_seq_ctrl: RTL and testbench

ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

---
 rtl/acc_pkg.sv | 15 +
 rtl/acc_accum.sv | 36 +++
 rtl/acc_seq_ctrl.sv | 112 +++++++++++
 tb/tb_acc_seq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator sequencer slice:
// default widths and the sequencer state encoding.
package acc_pkg;

    localparam int unsigned PSUM_W_DEF = 27;
    localparam int unsigned ACC_W_DEF  = 51;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/acc_accum.sv
// Accumulator placed beside acc_seq_ctrl by the parent:
// sign-extending adder with a clearable feedback register.
module acc_accum
    import acc_pkg::*;
#(
    parameter int unsigned PSUM_W = PSUM_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic [PSUM_W-1:0] acc_in1,
    input  logic              acc_st,
    input  logic              acc_en,
    output logic [ACC_W-1:0]  acc_sum
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_fb;

    assign w_ext   = {{(ACC_W-PSUM_W){acc_in1[PSUM_W-1]}}, acc_in1};
    assign w_fb    = acc_en ? r_acc : '0;
    assign acc_sum = w_ext + w_fb;

    // Feedback register: cleared by acc_st, otherwise tracks the sum
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
        end else if (acc_st) begin
            r_acc <= '0;
        end else begin
            r_acc <= acc_sum;
        end
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequencer that feeds partial sums to an external accumulator
// and hands out one result per group of len_m1+1 beats.
module acc_seq_ctrl
    import acc_pkg::*;
#(
    parameter int unsigned PSUM_W = PSUM_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  len_m1,
    input  logic [CNT_W-1:0]  grp_m1,
    output logic              busy,
    output logic              done,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [PSUM_W-1:0] psum_data,
    output logic [PSUM_W-1:0] acc_in1,
    output logic              acc_st,
    output logic              acc_en,
    input  logic [ACC_W-1:0]  acc_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data
);

    state_e           r_state;
    logic [CNT_W-1:0] r_len_m1;
    logic [CNT_W-1:0] r_grp_m1;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] r_grp_cnt;
    logic             r_res_valid;
    logic [ACC_W-1:0] r_res_data;

    logic w_accept;
    logic w_last_beat;
    logic w_last_grp;
    logic w_res_fire;

    assign w_accept    = psum_valid && psum_ready;
    assign w_last_beat = w_accept && (r_beat_cnt == r_len_m1);
    assign w_last_grp  = (r_grp_cnt == r_grp_m1);
    assign w_res_fire  = r_res_valid && res_ready;

    // A beat may only enter when its result slot can be freed
    assign psum_ready = (r_state == S_RUN) &&
                        (!r_res_valid || res_ready);

    assign acc_in1   = w_accept ? psum_data : '0;
    assign acc_en    = (r_beat_cnt != '0);
    assign acc_st    = (r_state != S_RUN);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FLUSH) && w_res_fire;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

    // Job sequencing: latch job shape, count beats and groups
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_len_m1   <= '0;
            r_grp_m1   <= '0;
            r_beat_cnt <= '0;
            r_grp_cnt  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len_m1   <= len_m1;
                        r_grp_m1   <= grp_m1;
                        r_beat_cnt <= '0;
                        r_grp_cnt  <= '0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last_beat) begin
                        r_beat_cnt <= '0;
                        r_grp_cnt  <= r_grp_cnt + 1'b1;
                        if (w_last_grp) begin
                            r_state <= S_FLUSH;
                        end
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (w_res_fire) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result slot: a new load wins over a same-cycle consume
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (w_last_beat) begin
            r_res_valid <= 1'b1;
            r_res_data  <= acc_sum;
        end else if (w_res_fire) begin
            r_res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl driving the acc_accum model:
// vector table plus hand sequences for backpressure and reset.
module tb_acc_seq_ctrl;

    localparam int PW = 27;
    localparam int AW = 51;
    localparam int CW = 8;

    typedef struct {
        logic          st;
        logic [CW-1:0] len;
        logic [CW-1:0] grp;
        logic          pv;
        logic [PW-1:0] pd;
        logic          rr;
        logic          e_pr;
        logic          e_en;
        logic          e_dn;
        logic          e_busy;
        logic          e_rv;
        logic [AW-1:0] e_rd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] len_m1 = '0;
    logic [CW-1:0] grp_m1 = '0;
    logic          busy;
    logic          done;
    logic          psum_valid = 1'b0;
    logic          psum_ready;
    logic [PW-1:0] psum_data = '0;
    logic [PW-1:0] acc_in1;
    logic          acc_st;
    logic          acc_en;
    logic [AW-1:0] acc_sum;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] res_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acc_seq_ctrl #(.PSUM_W(PW), .ACC_W(AW), .CNT_W(CW)) u_dut (
        .clk(clk), .rstn(rstn), .start(start),
        .len_m1(len_m1), .grp_m1(grp_m1),
        .busy(busy), .done(done),
        .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_data(psum_data), .acc_in1(acc_in1),
        .acc_st(acc_st), .acc_en(acc_en), .acc_sum(acc_sum),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    acc_accum #(.PSUM_W(PW), .ACC_W(AW)) u_acc (
        .clk(clk), .rstn(rstn), .acc_in1(acc_in1),
        .acc_st(acc_st), .acc_en(acc_en), .acc_sum(acc_sum)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int st, input int len,
                                input int grp, input int pv,
                                input int pd, input int rr,
                                input int pr, input int en,
                                input int dn, input int bz,
                                input int rv, input longint rd);
        vec_t v;
        v.st = st[0];
        v.len = CW'(len);
        v.grp = CW'(grp);
        v.pv = pv[0];
        v.pd = PW'(pd);
        v.rr = rr[0];
        v.e_pr = pr[0];
        v.e_en = en[0];
        v.e_dn = dn[0];
        v.e_busy = bz[0];
        v.e_rv = rv[0];
        v.e_rd = AW'(rd);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic [PW-1:0] e_in1;
        @(negedge clk);
        start = v.st;
        len_m1 = v.len;
        grp_m1 = v.grp;
        psum_valid = v.pv;
        psum_data = v.pd;
        res_ready = v.rr;
        #1;
        e_in1 = (v.pv && v.e_pr) ? v.pd : '0;
        chk({tag, ".psum_ready"}, 64'(psum_ready), 64'(v.e_pr));
        chk({tag, ".acc_en"}, 64'(acc_en), 64'(v.e_en));
        chk({tag, ".done"}, 64'(done), 64'(v.e_dn));
        chk({tag, ".acc_in1"}, 64'(acc_in1), 64'(e_in1));
        @(posedge clk);
        #1;
        chk({tag, ".busy"}, 64'(busy), 64'(v.e_busy));
        chk({tag, ".res_valid"}, 64'(res_valid), 64'(v.e_rv));
        chk({tag, ".res_data"}, 64'(res_data), 64'(v.e_rd));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".psum_ready"}, 64'(psum_ready), 64'd0);
        chk({tag, ".acc_in1"}, 64'(acc_in1), 64'd0);
        chk({tag, ".acc_en"}, 64'(acc_en), 64'd0);
        chk({tag, ".acc_st"}, 64'(acc_st), 64'd1);
        chk({tag, ".res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, ".res_data"}, 64'(res_data), 64'd0);
        chk({tag, ".acc_sum"}, 64'(acc_sum), 64'd0);
    endtask

    initial begin
        vec_t tbl[$];

        // len 3, one group: 5+16+32+1
        tbl.push_back(mk(1, 3, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5,   1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 16,  1, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32,  1, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1,   1, 1, 1, 0, 1, 1, 54));
        tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 54));
        // len 1, two groups: -7+3, 100-1
        tbl.push_back(mk(1, 1, 1, 0, 0,   1, 0, 0, 0, 1, 0, 54));
        tbl.push_back(mk(0, 0, 0, 1, -7,  1, 1, 0, 0, 1, 0, 54));
        tbl.push_back(mk(0, 0, 0, 1, 3,   1, 1, 1, 0, 1, 1, -4));
        tbl.push_back(mk(0, 0, 0, 1, 100, 1, 1, 0, 0, 1, 0, -4));
        tbl.push_back(mk(0, 0, 0, 1, -1,  1, 1, 1, 0, 1, 1, 99));
        tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 99));
        // gaps with junk data on the idle beats
        tbl.push_back(mk(1, 1, 0, 0, 0,   1, 0, 0, 0, 1, 0, 99));
        tbl.push_back(mk(0, 0, 0, 1, 9,   1, 1, 0, 0, 1, 0, 99));
        tbl.push_back(mk(0, 0, 0, 0, 123, 1, 1, 1, 0, 1, 0, 99));
        tbl.push_back(mk(0, 0, 0, 0, -50, 1, 1, 1, 0, 1, 0, 99));
        tbl.push_back(mk(0, 0, 0, 1, 4,   1, 1, 1, 0, 1, 1, 13));
        tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 13));
        // len 0, three groups: load and consume in the same cycle
        tbl.push_back(mk(1, 0, 2, 0, 0,   1, 0, 0, 0, 1, 0, 13));
        tbl.push_back(mk(0, 0, 0, 1, 7,   1, 1, 0, 0, 1, 1, 7));
        tbl.push_back(mk(0, 0, 0, 1, -3,  1, 1, 0, 0, 1, 1, -3));
        tbl.push_back(mk(0, 0, 0, 1, 20,  1, 1, 0, 0, 1, 1, 20));
        tbl.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 20));

        // reset state
        #2;
        chk_reset_outputs("por");
        @(negedge clk);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // start while busy: len stays 3, no restart
        apply(mk(1, 3, 0, 0, 0, 1, 0, 0, 0, 1, 0, 20), "sb0");
        apply(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 20), "sb1");
        apply(mk(1, 0, 0, 1, 2, 1, 1, 1, 0, 1, 0, 20), "sb2");
        apply(mk(1, 5, 3, 1, 3, 1, 1, 1, 0, 1, 0, 20), "sb3");
        apply(mk(1, 5, 3, 1, 4, 1, 1, 1, 0, 1, 1, 10), "sb4");
        apply(mk(1, 5, 3, 0, 0, 1, 0, 0, 1, 0, 0, 10), "sb5");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10), "sb6");

        // backpressure on the second result
        apply(mk(1, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 10), "bp0");
        apply(mk(0, 0, 0, 1, 2,  0, 1, 0, 0, 1, 0, 10), "bp1");
        apply(mk(0, 0, 0, 1, 3,  0, 1, 1, 0, 1, 1, 5), "bp2");
        apply(mk(0, 0, 0, 1, 10, 0, 0, 0, 0, 1, 1, 5), "bp3");
        apply(mk(0, 0, 0, 1, 10, 0, 0, 0, 0, 1, 1, 5), "bp4");
        apply(mk(0, 0, 0, 1, 10, 1, 1, 0, 0, 1, 0, 5), "bp5");
        apply(mk(0, 0, 0, 1, 11, 0, 1, 1, 0, 1, 1, 21), "bp6");
        apply(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 21), "bp7");
        apply(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 21), "bp8");

        // reset in the middle of a group
        apply(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 21), "rs0");
        apply(mk(0, 0, 0, 1, 8, 1, 1, 0, 0, 1, 0, 21), "rs1");
        @(negedge clk);
        psum_valid = 1'b1;
        psum_data = PW'(5);
        res_ready = 1'b1;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        chk_reset_outputs("mid_rst_edge");
        @(negedge clk);
        psum_valid = 1'b0;
        rstn = 1'b1;

        // clean job after reset: sign extension at both extremes
        apply(mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0), "pr0");
        apply(mk(0, 0, 0, 1, 27'h7FFFFFF, 1, 1, 0, 0, 1, 1, -1),
              "pr1");
        apply(mk(0, 0, 0, 1, 27'h3FFFFFF, 1, 1, 0, 0, 1, 1,
                 64'h3FFFFFF), "pr2");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 64'h3FFFFFF),
              "pr3");
        // accumulation after reset starts from zero
        apply(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 64'h3FFFFFF),
              "pr4");
        apply(mk(0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 64'h3FFFFFF),
              "pr5");
        apply(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 1, 1, 3), "pr6");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 3), "pr7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
